// File: rtl/regdest_pkg.sv
// regdest_pkg: destination-select codes and fixed register numbers shared by the write-back scheduler.
package regdest_pkg;
    localparam logic [2:0] DEST_RT = 3'b000;
    localparam logic [2:0] DEST_RD = 3'b001;
    localparam logic [2:0] DEST_RA = 3'b010;
    localparam logic [2:0] DEST_SP = 3'b011;
    localparam logic [2:0] DEST_RS = 3'b100;
    localparam logic [4:0] REG_RA = 5'd31;
    localparam logic [4:0] REG_SP = 5'd29;
endpackage

// File: rtl/regdest_wb_scheduler_if.sv
// regdest_wb_scheduler_if: request ports A/B and write-back bus of the scheduler.
// Bypass lookup signals exist only when REGDEST_BYPASS_EN is defined.
interface regdest_wb_scheduler_if #(parameter int DATA_W = 32);
    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_sel;
    logic [4:0]        a_rs;
    logic [4:0]        a_rt;
    logic [4:0]        a_rd;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [DATA_W-1:0] b_data;
    logic [2:0]        mux_regDest_control;
    logic [4:0]        inst25_21_out;
    logic [4:0]        inst20_16_out;
    logic [4:0]        inst15_11_out;
    logic              reg_write;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_dest;
    logic              sel_err;
`ifdef REGDEST_BYPASS_EN
    logic [4:0]        byp_addr;
    logic              byp_hit;
`endif
    modport master (
        output a_valid, a_sel, a_rs, a_rt, a_rd, a_data, b_valid, b_data,
`ifdef REGDEST_BYPASS_EN
        output byp_addr,
        input  byp_hit,
`endif
        input  a_ready, b_ready, mux_regDest_control, inst25_21_out, inst20_16_out,
        input  inst15_11_out, reg_write, wb_data, wb_dest, sel_err
    );
    modport slave (
        input  a_valid, a_sel, a_rs, a_rt, a_rd, a_data, b_valid, b_data,
`ifdef REGDEST_BYPASS_EN
        input  byp_addr,
        output byp_hit,
`endif
        output a_ready, b_ready, mux_regDest_control, inst25_21_out, inst20_16_out,
        output inst15_11_out, reg_write, wb_data, wb_dest, sel_err
    );
endinterface

// File: rtl/regdest_wb_scheduler_resolve.sv
// regdest_resolve: maps a destination code plus instruction fields to a register number.
module regdest_resolve
    import regdest_pkg::*;
(
    input  logic [2:0] sel_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic [4:0] rd_i,
    output logic [4:0] dest_o,
    output logic       valid_o
);
    always_comb begin
        dest_o  = sel_i == DEST_RT ? rt_i :
                  sel_i == DEST_RD ? rd_i :
                  sel_i == DEST_RA ? REG_RA :
                  sel_i == DEST_SP ? REG_SP :
                  sel_i == DEST_RS ? rs_i : 5'd0;
        valid_o = sel_i <= DEST_RS;
    end
endmodule

// File: rtl/regdest_wb_scheduler.sv
// regdest_wb_scheduler: arbitrates the single register-file write port between control (A) and stack (B).
// Define REGDEST_BYPASS_EN to add the byp_addr/byp_hit pending-write lookup.
module regdest_wb_scheduler
    import regdest_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int DATA_W       = 32
) (
    input  logic clk,
    input  logic reset,
    regdest_wb_scheduler_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic              a_full_q, a_full_d, b_full_q, b_full_d;
    logic [2:0]        a_sel_q, a_sel_d;
    logic [4:0]        a_rs_q, a_rs_d, a_rt_q, a_rt_d, a_rd_q, a_rd_d;
    logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [2:0]        mux_q, mux_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, dest_q, dest_d;
    logic [DATA_W-1:0] wb_q, wb_d;
    logic              rw_q, rw_d, err_q, err_d;
    logic              grant_a, grant_b, a_acc, b_acc, a_ok;
    logic [4:0]        a_dest;

    regdest_resolve u_res (
        .sel_i   (a_sel_q),
        .rs_i    (a_rs_q),
        .rt_i    (a_rt_q),
        .rd_i    (a_rd_q),
        .dest_o  (a_dest),
        .valid_o (a_ok)
    );

    // A wins unless B has already lost STARVE_LIMIT arbitrations in a row.
    assign grant_a = a_full_q && (!b_full_q || starve_q < LIM);
    assign grant_b = b_full_q && !grant_a;
    assign bus.a_ready = !a_full_q || grant_a;
    assign bus.b_ready = !b_full_q || grant_b;
    assign a_acc = bus.a_valid && bus.a_ready;
    assign b_acc = bus.b_valid && bus.b_ready;

    always_comb begin
        a_full_d = a_acc || (a_full_q && !grant_a);
        b_full_d = b_acc || (b_full_q && !grant_b);
        a_sel_d  = a_acc ? bus.a_sel  : a_sel_q;
        a_rs_d   = a_acc ? bus.a_rs   : a_rs_q;
        a_rt_d   = a_acc ? bus.a_rt   : a_rt_q;
        a_rd_d   = a_acc ? bus.a_rd   : a_rd_q;
        a_data_d = a_acc ? bus.a_data : a_data_q;
        b_data_d = b_acc ? bus.b_data : b_data_q;
        starve_d = (b_full_q && !grant_b) ? (starve_q == LIM ? LIM : starve_q + 1'b1) : '0;
        mux_d    = mux_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        dest_d   = dest_q;
        wb_d     = wb_q;
        rw_d     = 1'b0;
        err_d    = grant_a && !a_ok;
        if (grant_a && a_ok) begin
            mux_d  = a_sel_q;
            rs_d   = a_rs_q;
            rt_d   = a_rt_q;
            rd_d   = a_rd_q;
            dest_d = a_dest;
            wb_d   = a_data_q;
            rw_d   = a_dest != 5'd0;
        end
        if (grant_b) begin
            mux_d  = DEST_SP;
            dest_d = REG_SP;
            wb_d   = b_data_q;
            rw_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            a_sel_q  <= '0;
            a_rs_q   <= '0;
            a_rt_q   <= '0;
            a_rd_q   <= '0;
            a_data_q <= '0;
            b_data_q <= '0;
            starve_q <= '0;
            mux_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            dest_q   <= '0;
            wb_q     <= '0;
            rw_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_full_q <= a_full_d;
            b_full_q <= b_full_d;
            a_sel_q  <= a_sel_d;
            a_rs_q   <= a_rs_d;
            a_rt_q   <= a_rt_d;
            a_rd_q   <= a_rd_d;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
            starve_q <= starve_d;
            mux_q    <= mux_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            dest_q   <= dest_d;
            wb_q     <= wb_d;
            rw_q     <= rw_d;
            err_q    <= err_d;
        end
    end

    assign bus.mux_regDest_control = mux_q;
    assign bus.inst25_21_out       = rs_q;
    assign bus.inst20_16_out       = rt_q;
    assign bus.inst15_11_out       = rd_q;
    assign bus.reg_write           = rw_q;
    assign bus.wb_data             = wb_q;
    assign bus.wb_dest             = dest_q;
    assign bus.sel_err             = err_q;

`ifdef REGDEST_BYPASS_EN
    // Any write still queued or landing this cycle makes the register unsafe to read.
    assign bus.byp_hit = bus.byp_addr != 5'd0 &&
                         ((a_full_q && a_ok && bus.byp_addr == a_dest) ||
                          (b_full_q && bus.byp_addr == REG_SP) ||
                          (rw_q && bus.byp_addr == dest_q));
`endif
endmodule

// File: tb/tb_regdest_wb_scheduler.sv
// tb_regdest_wb_scheduler: table-driven check of arbitration, latency, starvation, $0/invalid and reset.
module tb_regdest_wb_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regdest_wb_scheduler_if #(.DATA_W(32)) bus ();

    regdest_wb_scheduler #(.STARVE_LIMIT(3), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        av;
        logic [2:0]  asel;
        logic [4:0]  ars, art, ard;
        logic [31:0] adata;
        logic        bv;
        logic [31:0] bdata;
        logic        m;
        logic        ar, br, rw, err;
        logic [2:0]  mux;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [4:0]  frs, frt, frd;
    } vec_t;

    vec_t tv [27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] s, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] ad, input logic bv, input logic [31:0] bd);
        bus.a_valid = av;
        bus.a_sel   = s;
        bus.a_rs    = rs;
        bus.a_rt    = rt;
        bus.a_rd    = rd;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_data  = bd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{1,1,1,2,8,'h1234, 0,0, 1, 1,1,0,0, 0,0,0,       0,0,0};
        tv[1]  = '{0,0,0,0,0,0,      0,0, 1, 1,1,1,0, 1,8,'h1234,  1,2,8};
        tv[2]  = '{0,0,0,0,0,0,      0,0, 1, 1,1,0,0, 1,8,'h1234,  1,2,8};
        tv[3]  = '{1,0,3,5,4,'hAA,   1,'h7FF0, 1, 1,0,0,0, 1,8,'h1234, 1,2,8};
        tv[4]  = '{0,0,0,0,0,0,      0,0, 1, 1,1,1,0, 0,5,'hAA,    3,5,4};
        tv[5]  = '{0,0,0,0,0,0,      0,0, 1, 1,1,1,0, 3,29,'h7FF0, 3,5,4};
        tv[6]  = '{0,0,0,0,0,0,      0,0, 1, 1,1,0,0, 3,29,'h7FF0, 3,5,4};
        tv[7]  = '{1,1,0,0,10,1,     1,'hB0, 1, 1,0,0,0, 3,29,'h7FF0, 3,5,4};
        tv[8]  = '{1,1,0,0,11,2,     0,0, 1, 1,0,1,0, 1,10,1,      0,0,10};
        tv[9]  = '{1,1,0,0,12,3,     0,0, 1, 1,0,1,0, 1,11,2,      0,0,11};
        tv[10] = '{1,1,0,0,13,4,     0,0, 1, 0,1,1,0, 1,12,3,      0,0,12};
        tv[11] = '{1,1,0,0,14,5,     0,0, 1, 1,1,1,0, 3,29,'hB0,   0,0,12};
        tv[12] = '{1,1,0,0,14,5,     0,0, 1, 1,1,1,0, 1,13,4,      0,0,13};
        tv[13] = '{0,0,0,0,0,0,      0,0, 1, 1,1,1,0, 1,14,5,      0,0,14};
        tv[14] = '{0,0,0,0,0,0,      1,'h1000, 1, 1,1,0,0, 1,14,5, 0,0,14};
        tv[15] = '{0,0,0,0,0,0,      0,0, 1, 1,1,1,0, 3,29,'h1000, 0,0,14};
        tv[16] = '{1,2,7,8,9,'h31,   0,0, 1, 1,1,0,0, 3,29,'h1000, 0,0,14};
        tv[17] = '{0,0,0,0,0,0,      0,0, 1, 1,1,1,0, 2,31,'h31,   7,8,9};
        tv[18] = '{1,4,6,8,9,'h44,   0,0, 1, 1,1,0,0, 2,31,'h31,   7,8,9};
        tv[19] = '{0,0,0,0,0,0,      0,0, 1, 1,1,1,0, 4,6,'h44,    6,8,9};
        tv[20] = '{1,0,0,0,0,'h55,   0,0, 1, 1,1,0,0, 4,6,'h44,    6,8,9};
        tv[21] = '{0,0,0,0,0,0,      0,0, 0, 1,1,0,0, 0,0,0,       0,0,0};
        tv[22] = '{1,6,0,0,0,'h66,   0,0, 0, 1,1,0,0, 0,0,0,       0,0,0};
        tv[23] = '{0,0,0,0,0,0,      0,0, 0, 1,1,0,1, 0,0,0,       0,0,0};
        tv[24] = '{0,0,0,0,0,0,      0,0, 0, 1,1,0,0, 0,0,0,       0,0,0};
        tv[25] = '{1,1,0,0,3,'h77,   0,0, 0, 1,1,0,0, 0,0,0,       0,0,0};
        tv[26] = '{0,0,0,0,0,0,      0,0, 1, 1,1,1,0, 1,3,'h77,    0,0,3};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef REGDEST_BYPASS_EN
        bus.byp_addr = 5'd0;
`endif
        step();
        step();
        chk("rst_a_ready", 32'(bus.a_ready), 1);
        chk("rst_b_ready", 32'(bus.b_ready), 1);
        chk("rst_reg_write", 32'(bus.reg_write), 0);
        chk("rst_mux", 32'(bus.mux_regDest_control), 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_wb_dest", 32'(bus.wb_dest), 0);
        chk("rst_sel_err", 32'(bus.sel_err), 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 27; i++) begin
            drive(tv[i].av, tv[i].asel, tv[i].ars, tv[i].art, tv[i].ard, tv[i].adata, tv[i].bv, tv[i].bdata);
            step();
            chk($sformatf("v%0d_a_ready", i), 32'(bus.a_ready), 32'(tv[i].ar));
            chk($sformatf("v%0d_b_ready", i), 32'(bus.b_ready), 32'(tv[i].br));
            chk($sformatf("v%0d_reg_write", i), 32'(bus.reg_write), 32'(tv[i].rw));
            chk($sformatf("v%0d_sel_err", i), 32'(bus.sel_err), 32'(tv[i].err));
            if (tv[i].m) begin
                chk($sformatf("v%0d_mux", i), 32'(bus.mux_regDest_control), 32'(tv[i].mux));
                chk($sformatf("v%0d_wb_dest", i), 32'(bus.wb_dest), 32'(tv[i].dest));
                chk($sformatf("v%0d_wb_data", i), bus.wb_data, tv[i].data);
                chk($sformatf("v%0d_rs", i), 32'(bus.inst25_21_out), 32'(tv[i].frs));
                chk($sformatf("v%0d_rt", i), 32'(bus.inst20_16_out), 32'(tv[i].frt));
                chk($sformatf("v%0d_rd", i), 32'(bus.inst15_11_out), 32'(tv[i].frd));
            end
        end

        // Reset with both entries occupied: nothing may be written afterwards.
        drive(1, 0, 0, 9, 0, 'hCAFE, 1, 'hBEEF);
        step();
        chk("mid_b_ready", 32'(bus.b_ready), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        chk("mid_rst_reg_write", 32'(bus.reg_write), 0);
        chk("mid_rst_a_ready", 32'(bus.a_ready), 1);
        chk("mid_rst_b_ready", 32'(bus.b_ready), 1);
        chk("mid_rst_mux", 32'(bus.mux_regDest_control), 0);
        chk("mid_rst_wb_data", bus.wb_data, 0);
        chk("mid_rst_wb_dest", 32'(bus.wb_dest), 0);
        chk("mid_rst_rd", 32'(bus.inst15_11_out), 0);
        reset = 1'b1;
        step();
        chk("post_rst_reg_write0", 32'(bus.reg_write), 0);
        step();
        chk("post_rst_reg_write1", 32'(bus.reg_write), 0);
        chk("post_rst_wb_dest", 32'(bus.wb_dest), 0);

`ifdef REGDEST_BYPASS_EN
        drive(1, 2, 0, 0, 0, 'h99, 0, 0);
        bus.byp_addr = 5'd31;
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("byp_pending_31", 32'(bus.byp_hit), 1);
        bus.byp_addr = 5'd0;
        #1;
        chk("byp_zero", 32'(bus.byp_hit), 0);
        bus.byp_addr = 5'd5;
        #1;
        chk("byp_other", 32'(bus.byp_hit), 0);
        bus.byp_addr = 5'd31;
        step();
        chk("byp_wb_cycle_31", 32'(bus.byp_hit), 1);
        step();
        chk("byp_idle_31", 32'(bus.byp_hit), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regdest_wb_scheduler.md
Name: regdest_wb_scheduler

Overview:
- Schedules the single register-file write port between two requesters.
  - Port A: the main control FSM, which writes ALU results, loads and links.
  - Port B: the stack unit, which always updates $29.
- Drives the register-destination mux select, the regwrite strobe and the write-back data.
- Sits between the control unit, the stack unit and the mux_regDest/register bank.
- Lets a dual-write instruction (e.g. pop: rt plus $29) serialize over consecutive cycles without stalling the control FSM for more than one handshake.

Parameters:
- STARVE_LIMIT, 3, number of consecutive lost arbitrations after which port B is granted ahead of port A.
- DATA_W, 32, width of write-back data.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- a_valid  in  1  port A write request.
- a_ready  out  1  port A holding register empty; request accepted when a_valid && a_ready.
- a_sel  in  3  destination code: 000 rt, 001 rd, 010 $31, 011 $29, 100 rs; 101–111 invalid.
- a_rs  in  5  instruction bits 25:21.
- a_rt  in  5  instruction bits 20:16.
- a_rd  in  5  instruction bits 15:11.
- a_data  in  DATA_W  port A write data.
- b_valid  in  1  port B ($29) write request.
- b_ready  out  1  port B holding register empty.
- b_data  in  DATA_W  new stack-pointer value.
- mux_regDest_control  out  3  select to mux_regDest, registered.
- inst25_21_out  out  5  latched rs field for the mux.
- inst20_16_out  out  5  latched rt field for the mux.
- inst15_11_out  out  5  latched rd field for the mux.
- reg_write  out  1  register bank write enable, registered.
- wb_data  out  DATA_W  write-back data, registered.
- wb_dest  out  5  resolved destination register number, registered.
- sel_err  out  1  one-cycle pulse: invalid a_sel accepted.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Both holding registers empty; a_ready = b_ready = 1.
  - All registered outputs 0; starvation counter 0.
- Holding registers:
  - One entry per port. Port A stores sel, fields and data; port B stores data.
  - ready = entry empty || entry granted this cycle, so back-to-back acceptance is possible.
- Arbitration, each cycle, over occupied entries:
  - Grant A if A is occupied and (B is empty or starve_cnt < STARVE_LIMIT); otherwise grant B.
  - starve_cnt increments while B is occupied and loses, saturating at STARVE_LIMIT. It clears when B is granted or B is empty.
- Write-back latency:
  - The granted entry drives the outputs on the next clk edge; reg_write = 1 for exactly one cycle.
  - Request to reg_write is 2 cycles minimum: accept edge, then grant edge.
  - With no grant, reg_write = 0. mux_regDest_control, the fields and wb_data hold their last value.
- Destination resolution, wb_dest:
  - 000 → rt, 001 → rd, 010 → 31, 011 → 29, 100 → rs.
  - Port B always drives code 011 and wb_dest 29.
- $0 suppression: a resolved destination of 0 frees the entry but keeps reg_write = 0.
- Invalid sel: the entry is freed, reg_write = 0 and sel_err pulses 1 in the write-back cycle.
- Simultaneous A and B both occupied: A first (dual-write order rt then $29) unless the starvation rule fires.
- Port A writes to $29 and port B are not merged; both writes occur, in grant order, and the last write wins.
- A reset mid-sequence drops any pending entries with no partial write.

Optional Feature:
- Macro: REGDEST_BYPASS_EN.
- When defined, adds two ports:
  - byp_addr  in  5: register being read.
  - byp_hit  out  1: combinational.
- byp_hit = 1 when byp_addr != 0 and byp_addr equals the resolved destination of either occupied holding entry or of the current reg_write cycle.
- byp_hit lets the control FSM stall reads of pending registers.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package regdest_pkg holds:
  - the 3-bit destination-code constants: DEST_RT, DEST_RD, DEST_RA = 010, DEST_SP = 011, DEST_RS;
  - the register-number constants REG_RA = 31, REG_SP = 29.
- One natural sub-module: regdest_resolve, a combinational code+fields→register number function, shared by the write path and the bypass compare.

Test Plan:
- Single A write: a_sel=001, a_rd=8, a_data=0x1234 → two cycles later reg_write=1, wb_dest=8, mux_regDest_control=001, wb_data=0x1234, for one cycle.
- Dual write: A (sel=000, rt=5, 0xAA) and B (0x7FF0) in the same cycle → writes $5 then $29 on consecutive cycles; both readys high again after grant.
- Starvation: hold A continuously busy with B pending, STARVE_LIMIT=3 → B granted on the 4th arbitration cycle; counter cleared.
- $0 and invalid: a_sel=000 with rt=0 → no reg_write, entry freed. a_sel=110 → sel_err=1 for one cycle, no reg_write.
- Reset mid-operation: both entries occupied, reset=0 for one edge → no reg_write, readys=1, outputs 0.
- Bypass (REGDEST_BYPASS_EN): pending A to $31 (sel=010), byp_addr=31 → byp_hit=1; byp_addr=0 → byp_hit=0.
